// File: rtl/spram_arbiter.sv
// spram_arbiter
//   Shares one single-port, output-registered block RAM between two
//   independent requesters (A and B). Each access runs IDLE -> ACCESS -> DATA:
//   the winner's wren/address/data are latched at the grant edge, the RAM
//   samples them at the end of ACCESS, and ram_q is captured into q_x at the
//   end of DATA together with a one-cycle ack_x pulse.
//
// Ports
//   clock, reset_n                 single clock, asynchronous active-low reset
//   req_x, wren_x                  level request and write(1)/read(0) select
//   address_x, data_x              access fields, sampled at the grant edge
//   ack_x                          one-cycle completion pulse
//   q_x                            read data, held until x's next completion
//   ram_wren/ram_address/ram_data  registered RAM port controls
//   ram_q                          RAM output (registered inside the RAM)
//   busy                           high whenever the FSM is not IDLE
module spram_arbiter #(
    parameter int WIDTH      = 16,
    parameter int WIDTHAD    = 10,
    parameter int PRIORITY_A = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_a,
    input  logic               wren_a,
    input  logic [WIDTHAD-1:0] address_a,
    input  logic [WIDTH-1:0]   data_a,
    output logic               ack_a,
    output logic [WIDTH-1:0]   q_a,
    input  logic               req_b,
    input  logic               wren_b,
    input  logic [WIDTHAD-1:0] address_b,
    input  logic [WIDTH-1:0]   data_b,
    output logic               ack_b,
    output logic [WIDTH-1:0]   q_b,
    output logic               ram_wren,
    output logic [WIDTHAD-1:0] ram_address,
    output logic [WIDTH-1:0]   ram_data,
    input  logic [WIDTH-1:0]   ram_q,
    output logic               busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DATA   = 2'd2;

    // Grant encoding: 0 = A, 1 = B.
    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    logic [1:0]         state_q,       state_d;
    logic               grant_q,       grant_d;
    logic               last_grant_q,  last_grant_d;
    logic               ack_a_q,       ack_a_d;
    logic               ack_b_q,       ack_b_d;
    logic [WIDTH-1:0]   q_a_q,         q_a_d;
    logic [WIDTH-1:0]   q_b_q,         q_b_d;
    logic               ram_wren_q,    ram_wren_d;
    logic [WIDTHAD-1:0] ram_address_q, ram_address_d;
    logic [WIDTH-1:0]   ram_data_q,    ram_data_d;
    logic               busy_q,        busy_d;

    logic elig_a, elig_b, pick_b;

    // A requester is masked during its own ack cycle so that a req held
    // across the ack is not immediately re-granted for the same access.
    assign elig_a = req_a & ~ack_a_q;
    assign elig_b = req_b & ~ack_b_q;

    // B wins if it is the only eligible requester, or on a tie when
    // round-robin is selected and A was served last.
    assign pick_b = elig_b & (~elig_a |
                    ((PRIORITY_A == 0) && (last_grant_q == GRANT_A)));

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        ack_a_d       = 1'b0;
        ack_b_d       = 1'b0;
        q_a_d         = q_a_q;
        q_b_d         = q_b_q;
        ram_wren_d    = ram_wren_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;

        case (state_q)
            S_IDLE: begin
                ram_wren_d = 1'b0;
                if (elig_a | elig_b) begin
                    grant_d       = pick_b;
                    last_grant_d  = pick_b;
                    ram_wren_d    = pick_b ? wren_b    : wren_a;
                    ram_address_d = pick_b ? address_b : address_a;
                    ram_data_d    = pick_b ? data_b    : data_a;
                    state_d       = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // RAM samples the port at this edge; only one write cycle.
                ram_wren_d = 1'b0;
                state_d    = S_DATA;
            end
            S_DATA: begin
                if (grant_q == GRANT_B) begin
                    q_b_d   = ram_q;
                    ack_b_d = 1'b1;
                end else begin
                    q_a_d   = ram_q;
                    ack_a_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                ram_wren_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            grant_q       <= GRANT_A;
            last_grant_q  <= GRANT_B;
            ack_a_q       <= 1'b0;
            ack_b_q       <= 1'b0;
            q_a_q         <= '0;
            q_b_q         <= '0;
            ram_wren_q    <= 1'b0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            ack_a_q       <= ack_a_d;
            ack_b_q       <= ack_b_d;
            q_a_q         <= q_a_d;
            q_b_q         <= q_b_d;
            ram_wren_q    <= ram_wren_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            busy_q        <= busy_d;
        end
    end

    assign ack_a       = ack_a_q;
    assign ack_b       = ack_b_q;
    assign q_a         = q_a_q;
    assign q_b         = q_b_q;
    assign ram_wren    = ram_wren_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter. Two instances share the same requester
// stimulus: dut0 uses round-robin tie-break, dut1 gives A fixed priority.
// Each has its own behavioural single-port RAM (registered q, write-through).
module tb_spram_arbiter;

    localparam int W  = 16;
    localparam int AW = 10;

    logic          clock, reset_n;
    logic          req_a, wren_a, req_b, wren_b;
    logic [AW-1:0] address_a, address_b;
    logic [W-1:0]  data_a, data_b;

    logic          ack_a0, ack_b0, ram_wren0, busy0;
    logic [W-1:0]  q_a0, q_b0, ram_data0, ram_q0;
    logic [AW-1:0] ram_address0;
    logic          ack_a1, ack_b1, ram_wren1, busy1;
    logic [W-1:0]  q_a1, q_b1, ram_data1, ram_q1;
    logic [AW-1:0] ram_address1;

    // backdoor preload port into both RAM models
    logic          bk_we;
    logic [AW-1:0] bk_addr;
    logic [W-1:0]  bk_data;

    logic [W-1:0]  mem0 [0:(1<<AW)-1];
    logic [W-1:0]  mem1 [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    spram_arbiter #(.WIDTH(W), .WIDTHAD(AW), .PRIORITY_A(0)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .req_a(req_a), .wren_a(wren_a), .address_a(address_a), .data_a(data_a),
        .ack_a(ack_a0), .q_a(q_a0),
        .req_b(req_b), .wren_b(wren_b), .address_b(address_b), .data_b(data_b),
        .ack_b(ack_b0), .q_b(q_b0),
        .ram_wren(ram_wren0), .ram_address(ram_address0), .ram_data(ram_data0),
        .ram_q(ram_q0), .busy(busy0)
    );

    spram_arbiter #(.WIDTH(W), .WIDTHAD(AW), .PRIORITY_A(1)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .req_a(req_a), .wren_a(wren_a), .address_a(address_a), .data_a(data_a),
        .ack_a(ack_a1), .q_a(q_a1),
        .req_b(req_b), .wren_b(wren_b), .address_b(address_b), .data_b(data_b),
        .ack_b(ack_b1), .q_b(q_b1),
        .ram_wren(ram_wren1), .ram_address(ram_address1), .ram_data(ram_data1),
        .ram_q(ram_q1), .busy(busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bk_we) begin
            mem0[bk_addr] <= bk_data;
            mem1[bk_addr] <= bk_data;
        end else begin
            if (ram_wren0) mem0[ram_address0] <= ram_data0;
            if (ram_wren1) mem1[ram_address1] <= ram_data1;
        end
        ram_q0 <= ram_wren0 ? ram_data0 : mem0[ram_address0];
        ram_q1 <= ram_wren1 ? ram_data1 : mem1[ram_address1];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bk(input logic [AW-1:0] a, input logic [W-1:0] d);
        bk_we = 1'b1; bk_addr = a; bk_data = d;
        tick();
        bk_we = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        req_a = 0; wren_a = 0; address_a = '0; data_a = '0;
        req_b = 0; wren_b = 0; address_b = '0; data_b = '0;
        bk_we = 0; bk_addr = '0; bk_data = '0;

        bk(10'h005, 16'hBEEF);
        bk(10'h010, 16'h5555);

        // reset state
        chk("rst_ack_a", ack_a0, 0);
        chk("rst_ack_b", ack_b0, 0);
        chk("rst_q_a", q_a0, 0);
        chk("rst_q_b", q_b0, 0);
        chk("rst_wren", ram_wren0, 0);
        chk("rst_addr", ram_address0, 0);
        chk("rst_data", ram_data0, 0);
        chk("rst_busy", busy0, 0);
        reset_n = 1'b1;
        tick();

        // single read by A; fields changed after the grant must not matter
        req_a = 1; wren_a = 0; address_a = 10'h005;
        tick();
        chk("rd_busy", busy0, 1);
        chk("rd_addr", ram_address0, 10'h005);
        chk("rd_wren", ram_wren0, 0);
        req_a = 0; address_a = 10'h000;
        tick();
        chk("rd_ack_early", ack_a0, 0);
        tick();
        chk("rd_ack", ack_a0, 1);
        chk("rd_q_a", q_a0, 16'hBEEF);
        chk("rd_ack_b", ack_b0, 0);
        chk("rd_q_b", q_b0, 0);
        tick();
        chk("rd_ack_pulse", ack_a0, 0);
        chk("rd_idle", busy0, 0);
        chk("rd_q_a_held", q_a0, 16'hBEEF);

        // B write 0x1234 -> 0x3FF, then read back holding req_b
        req_b = 1; wren_b = 1; address_b = 10'h3FF; data_b = 16'h1234;
        tick();
        chk("wr_wren", ram_wren0, 1);
        chk("wr_addr", ram_address0, 10'h3FF);
        chk("wr_data", ram_data0, 16'h1234);
        wren_b = 0; data_b = 16'h0000;
        tick();
        chk("wr_wren_drop", ram_wren0, 0);
        tick();
        chk("wr_ack_b", ack_b0, 1);
        chk("wr_q_b", q_b0, 16'h1234);
        chk("wr_q_a_held", q_a0, 16'hBEEF);
        // held req is masked in its ack cycle, so the next ack is 4 cycles on
        tick();
        chk("rb_ack_gap1", ack_b0, 0);
        chk("rb_idle_gap", busy0, 0);
        tick();
        chk("rb_ack_gap2", ack_b0, 0);
        chk("rb_addr", ram_address0, 10'h3FF);
        tick();
        chk("rb_ack_gap3", ack_b0, 0);
        tick();
        chk("rb_ack_b", ack_b0, 1);
        chk("rb_q_b", q_b0, 16'h1234);
        req_b = 0;
        tick();
        chk("rb_idle", busy0, 0);

        // round-robin: both held from reset; last_grant resets to B so A first
        reset_n = 1'b0;
        #2;
        chk("rst2_q_b", q_b0, 0);
        req_a = 1; wren_a = 0; address_a = 10'h005;
        req_b = 1; wren_b = 0; address_b = 10'h3FF;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("rr_ack_a_%0d", k), ack_a0, (k == 2 || k == 8));
            chk($sformatf("rr_ack_b_%0d", k), ack_b0, (k == 5 || k == 11));
            if (k == 2) chk("rr_q_a", q_a0, 16'hBEEF);
            if (k == 5) chk("rr_q_b", q_b0, 16'h1234);
        end
        req_a = 0; req_b = 0;
        tick();
        chk("rr_idle", busy0, 0);

        // fixed priority: make A the last grant, then a simultaneous tie
        req_a = 1;
        tick();
        req_a = 0;
        tick(); tick(); tick();
        req_a = 1; req_b = 1;
        tick();
        chk("tie_rr_picks_b", ram_address0, 10'h3FF);
        chk("tie_pa_picks_a", ram_address1, 10'h005);
        req_a = 0;
        tick();
        tick();
        chk("pa_ack_a", ack_a1, 1);
        chk("pa_ack_b_not", ack_b1, 0);
        chk("pa_q_a", q_a1, 16'hBEEF);
        tick(); tick(); tick();
        chk("pa_ack_b", ack_b1, 1);
        chk("pa_q_b", q_b1, 16'h1234);
        req_b = 0;
        tick(); tick(); tick();
        chk("pa_idle0", busy0, 0);
        chk("pa_idle1", busy1, 0);

        // reset during a write's ACCESS cycle: write must not land
        req_a = 1; wren_a = 1; address_a = 10'h010; data_a = 16'hAAAA;
        tick();
        chk("mw_wren", ram_wren0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mw_wren_async", ram_wren0, 0);
        chk("mw_busy", busy0, 0);
        chk("mw_addr", ram_address0, 0);
        chk("mw_data", ram_data0, 0);
        chk("mw_q_a", q_a0, 0);
        req_a = 0; wren_a = 0; data_a = '0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("mw_no_ack1", ack_a0, 0);
        tick();
        chk("mw_no_ack2", ack_a0, 0);
        req_a = 1; address_a = 10'h010;
        tick();
        req_a = 0;
        tick();
        tick();
        chk("mw_rd_ack", ack_a0, 1);
        chk("mw_rd_q", q_a0, 16'h5555);
        tick();

        // B request withdrawn while A is mid-access is never served
        req_a = 1; address_a = 10'h005;
        tick();
        req_a = 0;
        req_b = 1; address_b = 10'h3FF;
        tick();
        req_b = 0;
        tick();
        chk("wd_ack_a", ack_a0, 1);
        chk("wd_ack_b0", ack_b0, 0);
        tick();
        chk("wd_ack_b1", ack_b0, 0);
        chk("wd_idle1", busy0, 0);
        tick();
        chk("wd_ack_b2", ack_b0, 0);
        chk("wd_idle2", busy0, 0);
        chk("wd_q_b", q_b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
